// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse keyer.
//   state_t        - keyer FSM states
//   UNITS_*        - duration of each element in Morse time units
//   ASCII_SPACE    - word-space character code
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SGAP,
        LGAP,
        WGAP
    } state_t;

    localparam logic [2:0] UNITS_DOT  = 3'd1;
    localparam logic [2:0] UNITS_DASH = 3'd3;
    localparam logic [2:0] UNITS_SGAP = 3'd1;
    localparam logic [2:0] UNITS_LGAP = 3'd3;
    localparam logic [2:0] UNITS_WGAP = 3'd7;

    localparam logic [6:0] ASCII_SPACE = 7'h20;

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational character-to-Morse lookup.
// Ports:
//   char_in  in  7  ASCII character (lowercase a-z folded to uppercase)
//   valid    out 1  character is A-Z, 0-9 or space
//   is_space out 1  character is the word space
//   len      out 3  number of symbols (1..5), 0 for space/unsupported
//   pattern  out 5  symbols MSB-first, left-aligned; 1 = dash, 0 = dot
module morse_rom
    import morse_pkg::*;
(
    input  logic [6:0] char_in,
    output logic       valid,
    output logic       is_space,
    output logic [2:0] len,
    output logic [4:0] pattern
);

    logic [6:0] folded;

    always_comb begin
        folded = char_in;
        if (char_in >= 7'h61 && char_in <= 7'h7A) begin
            folded[5] = 1'b0;
        end
    end

    always_comb begin
        valid    = 1'b1;
        is_space = 1'b0;
        len      = 3'd0;
        pattern  = 5'b00000;
        case (folded)
            ASCII_SPACE: is_space = 1'b1;
            7'h41: {len, pattern} = {3'd2, 5'b01000}; // A .-
            7'h42: {len, pattern} = {3'd4, 5'b10000}; // B -...
            7'h43: {len, pattern} = {3'd4, 5'b10100}; // C -.-.
            7'h44: {len, pattern} = {3'd3, 5'b10000}; // D -..
            7'h45: {len, pattern} = {3'd1, 5'b00000}; // E .
            7'h46: {len, pattern} = {3'd4, 5'b00100}; // F ..-.
            7'h47: {len, pattern} = {3'd3, 5'b11000}; // G --.
            7'h48: {len, pattern} = {3'd4, 5'b00000}; // H ....
            7'h49: {len, pattern} = {3'd2, 5'b00000}; // I ..
            7'h4A: {len, pattern} = {3'd4, 5'b01110}; // J .---
            7'h4B: {len, pattern} = {3'd3, 5'b10100}; // K -.-
            7'h4C: {len, pattern} = {3'd4, 5'b01000}; // L .-..
            7'h4D: {len, pattern} = {3'd2, 5'b11000}; // M --
            7'h4E: {len, pattern} = {3'd2, 5'b10000}; // N -.
            7'h4F: {len, pattern} = {3'd3, 5'b11100}; // O ---
            7'h50: {len, pattern} = {3'd4, 5'b01100}; // P .--.
            7'h51: {len, pattern} = {3'd4, 5'b11010}; // Q --.-
            7'h52: {len, pattern} = {3'd3, 5'b01000}; // R .-.
            7'h53: {len, pattern} = {3'd3, 5'b00000}; // S ...
            7'h54: {len, pattern} = {3'd1, 5'b10000}; // T -
            7'h55: {len, pattern} = {3'd3, 5'b00100}; // U ..-
            7'h56: {len, pattern} = {3'd4, 5'b00010}; // V ...-
            7'h57: {len, pattern} = {3'd3, 5'b01100}; // W .--
            7'h58: {len, pattern} = {3'd4, 5'b10010}; // X -..-
            7'h59: {len, pattern} = {3'd4, 5'b10110}; // Y -.--
            7'h5A: {len, pattern} = {3'd4, 5'b11000}; // Z --..
            7'h30: {len, pattern} = {3'd5, 5'b11111}; // 0
            7'h31: {len, pattern} = {3'd5, 5'b01111}; // 1
            7'h32: {len, pattern} = {3'd5, 5'b00111}; // 2
            7'h33: {len, pattern} = {3'd5, 5'b00011}; // 3
            7'h34: {len, pattern} = {3'd5, 5'b00001}; // 4
            7'h35: {len, pattern} = {3'd5, 5'b00000}; // 5
            7'h36: {len, pattern} = {3'd5, 5'b10000}; // 6
            7'h37: {len, pattern} = {3'd5, 5'b11000}; // 7
            7'h38: {len, pattern} = {3'd5, 5'b11100}; // 8
            7'h39: {len, pattern} = {3'd5, 5'b11110}; // 9
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: keys one ASCII character as timed Morse on a single line.
// Optional sidetone generator enabled by defining MORSE_SIDETONE_EN.
// Ports:
//   clk     in  1  system clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   char_in in  7  character, sampled when a start is accepted
//   start   in  1  send request, ignored while busy
//   key     out 1  carrier on (mark)
//   busy    out 1  character in progress, through trailing gap
//   done    out 1  pulse on the last busy cycle
//   err     out 1  pulse when start sees an unsupported character
//   tone    out 1  sidetone square wave while key=1 (0 without the macro)
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 6_000_000,
    parameter int unsigned TONE_HALF   = 25_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] char_in,
    input  logic       start,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       tone
);

    localparam int unsigned UW = $clog2(UNIT_CYCLES);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [UW-1:0] UNIT_PREV = UW'(UNIT_CYCLES - 2);

    state_t        state;
    logic [UW-1:0] unit_cnt;
    logic [2:0]    unit_num;
    logic [2:0]    unit_target;
    logic [4:0]    shreg;
    logic [2:0]    sym_left;

    logic       rom_valid;
    logic       rom_space;
    logic [2:0] rom_len;
    logic [4:0] rom_pattern;

    morse_rom u_rom (
        .char_in  (char_in),
        .valid    (rom_valid),
        .is_space (rom_space),
        .len      (rom_len),
        .pattern  (rom_pattern)
    );

    logic last_unit;
    logic period_end;
    logic done_next;

    assign last_unit  = (unit_num == unit_target - 3'd1);
    assign period_end = (unit_cnt == UNIT_LAST) && last_unit;
    // done is registered, so it is raised one cycle ahead of the gap's final cycle
    assign done_next  = (state == LGAP || state == WGAP) && (unit_cnt == UNIT_PREV) && last_unit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            unit_cnt    <= '0;
            unit_num    <= '0;
            unit_target <= '0;
            shreg       <= '0;
            sym_left    <= '0;
            key         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!rom_valid) begin
                            err <= 1'b1;
                        end else begin
                            busy     <= 1'b1;
                            unit_cnt <= '0;
                            unit_num <= '0;
                            if (rom_space) begin
                                state       <= WGAP;
                                key         <= 1'b0;
                                unit_target <= UNITS_WGAP;
                            end else begin
                                state       <= MARK;
                                key         <= 1'b1;
                                shreg       <= rom_pattern;
                                sym_left    <= rom_len - 3'd1;
                                unit_target <= rom_pattern[4] ? UNITS_DASH : UNITS_DOT;
                            end
                        end
                    end
                end
                default: begin
                    if (done_next) begin
                        done <= 1'b1;
                    end
                    if (unit_cnt != UNIT_LAST) begin
                        unit_cnt <= unit_cnt + 1'b1;
                    end else begin
                        unit_cnt <= '0;
                        if (!last_unit) begin
                            unit_num <= unit_num + 3'd1;
                        end else begin
                            unit_num <= '0;
                            case (state)
                                MARK: begin
                                    key   <= 1'b0;
                                    shreg <= {shreg[3:0], 1'b0};
                                    if (sym_left != 3'd0) begin
                                        state       <= SGAP;
                                        unit_target <= UNITS_SGAP;
                                    end else begin
                                        state       <= LGAP;
                                        unit_target <= UNITS_LGAP;
                                    end
                                end
                                SGAP: begin
                                    key         <= 1'b1;
                                    state       <= MARK;
                                    sym_left    <= sym_left - 3'd1;
                                    unit_target <= shreg[4] ? UNITS_DASH : UNITS_DOT;
                                end
                                default: begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

`ifdef MORSE_SIDETONE_EN
    localparam int unsigned TW = $clog2(TONE_HALF + 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tone_cnt;

    // Divider runs only while the mark continues into the next cycle, so tone
    // clears in the same cycle key drops and restarts phase at each new mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone     <= 1'b0;
            tone_cnt <= '0;
        end else if (state == MARK && !period_end) begin
            if (tone_cnt == TONE_LAST) begin
                tone     <= ~tone;
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end else begin
            tone     <= 1'b0;
            tone_cnt <= '0;
        end
    end
`else
    assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;

    localparam int U  = 4;
    localparam int TH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] char_in = 7'h00;
    logic       start = 1'b0;
    logic       key, busy, done, err, tone;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic key;
        logic busy;
        logic done;
        logic err;
        logic tone;
    } rec_t;

    rec_t exp_q[$];
    int   pop_idx = 0;

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----."};

    morse_keyer #(.UNIT_CYCLES(U), .TONE_HALF(TH)) dut (
        .clk     (clk),
        .rst     (rst),
        .char_in (char_in),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .tone    (tone)
    );

    always #5 clk = ~clk;

    // Reference model: expands a character into its per-cycle expected outputs.
    task automatic build(input logic [6:0] ch, output int n, output bit ok);
        int    c;
        string code;
        bit    space;
        rec_t  r;
        rec_t  seq[$];
        c = int'(ch);
        if (c >= 97 && c <= 122) c = c - 32;
        ok = 1'b1;
        space = 1'b0;
        if (c == 32) space = 1'b1;
        else if (c >= 65 && c <= 90) code = letters[c - 65];
        else if (c >= 48 && c <= 57) code = digits[c - 48];
        else ok = 1'b0;
        if (!ok) begin
            r = '{key: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1, tone: 1'b0};
            exp_q.push_back(r);
            n = 1;
            return;
        end
        if (space) begin
            for (int j = 0; j < 7 * U; j++)
                seq.push_back('{key: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, tone: 1'b0});
        end else begin
            for (int i = 0; i < code.len(); i++) begin
                int mlen = (code[i] == "-") ? 3 * U : U;
                int glen = (i == code.len() - 1) ? 3 * U : U;
                for (int j = 0; j < mlen; j++) begin
                    r = '{key: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0, tone: 1'b0};
`ifdef MORSE_SIDETONE_EN
                    r.tone = ((j / TH) % 2) == 1;
`endif
                    seq.push_back(r);
                end
                for (int j = 0; j < glen; j++)
                    seq.push_back('{key: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, tone: 1'b0});
            end
        end
        n = seq.size();
        for (int k = 0; k < n; k++) begin
            r = seq[k];
            r.done = (k == n - 1);
            exp_q.push_back(r);
        end
    endtask

    // Caller is positioned at a negedge; returns at a negedge where the DUT is idle.
    task automatic issue(input logic [6:0] ch, input bit hold, input bit noise);
        int n;
        bit ok;
        build(ch, n, ok);
        char_in = ch;
        start = 1'b1;
        if (!ok) begin
            @(negedge clk);
            start = 1'b0;
            return;
        end
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k <= n) begin
                start = hold;
                if (noise) begin
                    char_in = 7'($urandom);
                    if ($urandom_range(0, 3) == 0) start = 1'b1;
                end
            end else begin
                start = 1'b0;
            end
        end
    endtask

    // Monitor: pops one expected record per cycle in which the DUT presents output.
    always @(negedge clk) begin
        if (!rst) begin
            rec_t got;
            rec_t want;
            got = '{key: key, busy: busy, done: done, err: err, tone: tone};
            if (busy || err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got k/b/d/e/t=%b expected no activity", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL trace[%0d] got k/b/d/e/t=%b expected %b", pop_idx, got, want);
                    end
                    pop_idx++;
                end
            end else begin
                checks++;
                if (key !== 1'b0 || done !== 1'b0 || tone !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs got k/b/d/e/t=%b expected 00000", got);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired with %0d expected records pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        logic [6:0] supported[37];
        string      pool;
        pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
        for (int i = 0; i < 37; i++) supported[i] = 7'(pool[i]);

        @(posedge clk);
        #1;
        checks++;
        if ({key, busy, done, err, tone} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got k/b/d/e/t=%b expected 00000", {key, busy, done, err, tone});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(7'h45, 1'b0, 1'b0);           // 'E' pulse
        repeat (2) @(negedge clk);
        issue(7'h61, 1'b0, 1'b0);           // 'a' folded
        issue(7'h20, 1'b0, 1'b0);           // space
        issue(7'h30, 1'b1, 1'b0);           // '0' back-to-back, start held
        issue(7'h23, 1'b0, 1'b0);           // '#' unsupported
        @(negedge clk);
        issue(7'h54, 1'b0, 1'b1);           // 'T' with ignored starts while busy
        @(negedge clk);

        // Reset in the middle of a dash of 'T'
        begin
            int n;
            bit ok;
            build(7'h54, n, ok);
            char_in = 7'h54;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (5) @(negedge clk);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            checks++;
            if (key !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort got key=%b busy=%b done=%b expected 0 0 0", key, busy, done);
            end
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (40) @(negedge clk);
        end
        issue(7'h45, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [6:0] ch;
            if ($urandom_range(0, 1) == 0) ch = supported[$urandom_range(0, 36)];
            else ch = 7'($urandom_range(0, 127));
            issue(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d pending records expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
